mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory
// with one-cycle read latency. Optional fetch starvation guard: ARB_STARVE_GUARD_EN.
module mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [DATA_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_write,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // state | meaning
   // IDLE  | no read response due this cycle
   // RSP_I | mem_rdata this cycle answers the fetch port
   // RSP_D | mem_rdata this cycle answers the data port
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RSP_I = 2'd1,
      RSP_D = 2'd2
   } state_t;

   state_t state;
   logic   fetch_first;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_LIMIT + 2);
   logic [CW-1:0] starve_cnt;

   assign fetch_first = (starve_cnt == CW'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!if_req || if_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   // Strict data priority; the limit only matters with the guard built in.
   assign fetch_first = (STARVE_LIMIT < 0);
`endif

   // Grants are gated by rst_n so nothing reaches the memory during reset.
   assign if_gnt = rst_n & if_req & (~d_req | fetch_first);
   assign d_gnt  = rst_n & d_req & ~if_gnt;

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_write = d_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (if_gnt) begin
         state <= RSP_I;
      end else if (d_gnt && !d_we) begin
         state <= RSP_D;
      end else begin
         state <= IDLE;
      end
   end

   // A single state register makes simultaneous rvalids unreachable.
   assign if_rvalid = (state == RSP_I);
   assign d_rvalid  = (state == RSP_D);
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// starvation / reset sequences, then random traffic against a reference model.
module tb_mem_arbiter;

`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit          ir;
      logic [31:0] ia;
      bit          dr;
      bit          dw;
      logic [31:0] da;
      logic [31:0] dd;
      logic [31:0] rd;
      bit          eig;
      bit          edg;
      bit          emw;
      logic [31:0] ema;
      logic [31:0] emd;
      bit          eiv;
      bit          edv;
   } vec_t;

   function automatic vec_t mk(bit ir, logic [31:0] ia, bit dr, bit dw,
                               logic [31:0] da, logic [31:0] dd, logic [31:0] rd,
                               bit eig, bit edg, bit emw, logic [31:0] ema,
                               logic [31:0] emd, bit eiv, bit edv);
      vec_t v;
      v.ir = ir;  v.ia = ia;  v.dr = dr;  v.dw = dw;  v.da = da;  v.dd = dd;
      v.rd = rd;  v.eig = eig; v.edg = edg; v.emw = emw; v.ema = ema;
      v.emd = emd; v.eiv = eiv; v.edv = edv;
      return v;
   endfunction

   // Called at posedge+1; rvalid expectations refer to the previous vector's grant.
   task automatic apply(input vec_t v, input int idx);
      if_req = v.ir; if_addr = v.ia; d_req = v.dr; d_we = v.dw;
      d_addr = v.da; d_wdata = v.dd; mem_rdata = v.rd;
      #1;
      chk($sformatf("v%0d if_gnt", idx), {31'd0, if_gnt}, {31'd0, v.eig});
      chk($sformatf("v%0d d_gnt", idx), {31'd0, d_gnt}, {31'd0, v.edg});
      chk($sformatf("v%0d mem_write", idx), {31'd0, mem_write}, {31'd0, v.emw});
      chk($sformatf("v%0d mem_addr", idx), mem_addr, v.ema);
      chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.emd);
      chk($sformatf("v%0d if_rvalid", idx), {31'd0, if_rvalid}, {31'd0, v.eiv});
      chk($sformatf("v%0d d_rvalid", idx), {31'd0, d_rvalid}, {31'd0, v.edv});
      if (v.eiv) chk($sformatf("v%0d if_rdata", idx), if_rdata, v.rd);
      if (v.edv) chk($sformatf("v%0d d_rdata", idx), d_rdata, v.rd);
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
   endtask

   vec_t vecs[15];
   int   prev_rsp, streak;
   bit   pend_i, pend_d, fw, dwin;

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      mem_rdata = 32'h0;
      // Requests during reset must not reach the memory.
      if_req = 1; d_req = 1; d_we = 1; d_addr = 32'h55; d_wdata = 32'h66; if_addr = 32'h77;
      #2;
      chk("rst if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst mem_write", {31'd0, mem_write}, 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'd0);
      chk("rst rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1'b1;

      //            ir  ia     dr dw da      dd        rd             eig edg emw ema     emd       eiv edv
      vecs[0]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,    32'h0,         0,  0,  0,  32'h0,  32'h0,    0,  0);
      vecs[1]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,    32'h0,         1,  0,  0,  32'h10, 32'h0,    0,  0);
      vecs[2]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,    32'hDEADBEEF,  0,  0,  0,  32'h0,  32'h0,    1,  0);
      vecs[3]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,    32'h0,         0,  0,  0,  32'h0,  32'h0,    0,  0);
      vecs[4]  = mk(1, 32'h20, 1, 0, 32'h40, 32'h9,    32'h0,         0,  1,  0,  32'h40, 32'h9,    0,  0);
      vecs[5]  = mk(1, 32'h20, 0, 0, 32'h0,  32'h0,    32'h5555,      1,  0,  0,  32'h20, 32'h0,    0,  1);
      vecs[6]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,    32'h6666,      0,  0,  0,  32'h0,  32'h0,    1,  0);
      vecs[7]  = mk(0, 32'h0,  1, 1, 32'h80, 32'h1234, 32'h0,         0,  1,  1,  32'h80, 32'h1234, 0,  0);
      vecs[8]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,    32'h7777,      0,  0,  0,  32'h0,  32'h0,    0,  0);
      vecs[9]  = mk(1, 32'h0,  0, 0, 32'h0,  32'h0,    32'h0,         1,  0,  0,  32'h0,  32'h0,    0,  0);
      vecs[10] = mk(1, 32'h4,  0, 0, 32'h0,  32'h0,    32'hA1,        1,  0,  0,  32'h4,  32'h0,    1,  0);
      vecs[11] = mk(1, 32'h8,  0, 0, 32'h0,  32'h0,    32'hA2,        1,  0,  0,  32'h8,  32'h0,    1,  0);
      vecs[12] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,    32'hA3,        0,  0,  0,  32'h0,  32'h0,    1,  0);
      vecs[13] = mk(0, 32'h0,  1, 0, 32'hC0, 32'h0,    32'h0,         0,  1,  0,  32'hC0, 32'h0,    0,  0);
      vecs[14] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,    32'hB0B0,      0,  0,  0,  32'h0,  32'h0,    0,  1);
      for (int i = 0; i < 15; i++) apply(vecs[i], i);

      // Starvation: data read held every cycle alongside a fetch request.
      idle_inputs();
      for (int i = 0; i < 10; i++) begin
         bit exp_i;
         exp_i = GUARD && ((i + 1) % (LIMIT + 1) == 0);
         if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
         #1;
         chk($sformatf("starve c%0d if_gnt", i), {31'd0, if_gnt}, {31'd0, exp_i});
         chk($sformatf("starve c%0d d_gnt", i), {31'd0, d_gnt}, {31'd0, !exp_i});
         @(posedge clk); #1;
      end
      idle_inputs();
      @(posedge clk); #1;

      // Reset while a data response is due and a fetch is being granted.
      d_req = 1; d_we = 0; d_addr = 32'h44;
      #1 chk("mid d_gnt", {31'd0, d_gnt}, 32'd1);
      @(posedge clk); #1;
      d_req = 0; if_req = 1; if_addr = 32'h30;
      #1;
      chk("mid d_rvalid", {31'd0, d_rvalid}, 32'd1);
      chk("mid if_gnt", {31'd0, if_gnt}, 32'd1);
      chk("mid mem_addr", mem_addr, 32'h30);
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("mid rst d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("mid rst mem_addr", mem_addr, 32'd0);
      chk("mid rst mem_write", {31'd0, mem_write}, 32'd0);
      @(posedge clk); #1;
      chk("mid rst if_rvalid", {31'd0, if_rvalid}, 32'd0);
      if_req = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1 chk("post rst rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      @(posedge clk); #1;
      chk("post rst dropped", {31'd0, if_rvalid}, 32'd0);
      if_req = 1; if_addr = 32'h34; d_req = 1; d_we = 0; d_addr = 32'h48;
      #1 chk("post rst d_gnt", {31'd0, d_gnt}, 32'd1);
      @(posedge clk); #1;
      d_req = 0;
      #1;
      chk("post rst d_rvalid", {31'd0, d_rvalid}, 32'd1);
      chk("post rst if_gnt", {31'd0, if_gnt}, 32'd1);
      @(posedge clk); #1;
      idle_inputs();
      #1 chk("post rst if_rvalid", {31'd0, if_rvalid}, 32'd1);
      @(posedge clk); #1;

      // Random traffic: requesters hold until granted.
      prev_rsp = 0; streak = 0; pend_i = 0; pend_d = 0;
      for (int c = 0; c < 400; c++) begin
         mem_rdata = $urandom;
         if (!pend_i) begin
            if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
         end
         if (!pend_d) begin
            d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom; d_wdata = $urandom;
         end
         #1;
         chk($sformatf("rnd%0d if_rvalid", c), {31'd0, if_rvalid}, {31'd0, prev_rsp == 1});
         chk($sformatf("rnd%0d d_rvalid", c), {31'd0, d_rvalid}, {31'd0, prev_rsp == 2});
         if (prev_rsp == 1) chk($sformatf("rnd%0d if_rdata", c), if_rdata, mem_rdata);
         if (prev_rsp == 2) chk($sformatf("rnd%0d d_rdata", c), d_rdata, mem_rdata);
         fw   = if_req && (!d_req || (GUARD && streak == LIMIT));
         dwin = d_req && !fw;
         chk($sformatf("rnd%0d if_gnt", c), {31'd0, if_gnt}, {31'd0, fw});
         chk($sformatf("rnd%0d d_gnt", c), {31'd0, d_gnt}, {31'd0, dwin});
         chk($sformatf("rnd%0d mem_addr", c), mem_addr, fw ? if_addr : (dwin ? d_addr : 32'd0));
         chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, dwin ? d_wdata : 32'd0);
         chk($sformatf("rnd%0d mem_write", c), {31'd0, mem_write}, {31'd0, dwin && d_we});
         prev_rsp = fw ? 1 : ((dwin && !d_we) ? 2 : 0);
         streak   = (if_req && !fw) ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
         pend_i   = if_req && !fw;
         pend_d   = d_req && !dwin;
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
